q2_panel_driver: RTL and testbench

- Automated front-panel operator for the q2 CPU. It drives the active-low panel switches (nsw, ndep_sw, nincp_sw, nstart_sw, nstop_sw) exactly as a human operator would.
- Accepts a stream of 12-bit program words over a valid/ready handshake. Each word is deposited with a deposit pulse followed by an increment-PC pulse.
- After the word flagged last, pulses start and then monitors q2's run output until halt.
- Sits between a host/ROM word source and the q2 panel inputs, replacing the manual switch bench.

---
 rtl/q2_panel_driver.sv | 167 ++++++++++++++++
 tb/tb_q2_panel_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/q2_panel_driver.sv
// Front-panel operator for q2: deposits a word stream through the panel switches, pulses start, then tracks run until halt.
// Pulse and settle widths are set by PULSE_CYCLES/GAP_CYCLES; the run input is double-flopped before use.
module q2_panel_driver #(
  parameter int PULSE_CYCLES = 16,
  parameter int GAP_CYCLES   = 16,
  parameter int RUN_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        stop_req,
  input  logic        run,
  output logic [11:0] nsw,
  output logic        ndep_sw,
  output logic        nincp_sw,
  output logic        nstart_sw,
  output logic        nstop_sw,
  output logic        busy,
  output logic        running,
  output logic        halted,
  output logic        timeout,
  output logic [11:0] word_count
);

  typedef enum logic [3:0] {
    IDLE, SETUP, DEP, DEP_GAP, INC, INC_GAP, START, WAIT_RUN, RUNNING
  } state_t;

  localparam logic [31:0] PULSE_END = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] GAP_END   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] RUN_END   = 32'(RUN_TIMEOUT - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] stop_cnt;
  logic        last_q;
  logic        run_s1;
  logic        run_s2;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      run_s1 <= run;
      run_s2 <= run_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      stop_cnt   <= '0;
      last_q     <= 1'b0;
      nsw        <= 12'hFFF;
      ndep_sw    <= 1'b1;
      nincp_sw   <= 1'b1;
      nstart_sw  <= 1'b1;
      nstop_sw   <= 1'b1;
      in_ready   <= 1'b1;
      running    <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      word_count <= '0;
    end else begin
      halted <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            nsw      <= ~in_data;
            last_q   <= in_last;
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= SETUP;
            if (word_count == 12'd0) timeout <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == GAP_END) begin
            cnt     <= '0;
            ndep_sw <= 1'b0;
            state   <= DEP;
          end else cnt <= cnt + 32'd1;
        end
        DEP: begin
          if (cnt == PULSE_END) begin
            cnt     <= '0;
            ndep_sw <= 1'b1;
            state   <= DEP_GAP;
          end else cnt <= cnt + 32'd1;
        end
        DEP_GAP: begin
          if (cnt == GAP_END) begin
            cnt      <= '0;
            nincp_sw <= 1'b0;
            state    <= INC;
          end else cnt <= cnt + 32'd1;
        end
        INC: begin
          if (cnt == PULSE_END) begin
            cnt      <= '0;
            nincp_sw <= 1'b1;
            state    <= INC_GAP;
          end else cnt <= cnt + 32'd1;
        end
        INC_GAP: begin
          if (cnt == GAP_END) begin
            cnt        <= '0;
            word_count <= word_count + 12'd1;
            nsw        <= 12'hFFF;
            if (last_q) begin
              nstart_sw <= 1'b0;
              state     <= START;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end else cnt <= cnt + 32'd1;
        end
        START: begin
          if (cnt == PULSE_END) begin
            cnt       <= '0;
            nstart_sw <= 1'b1;
            state     <= WAIT_RUN;
          end else cnt <= cnt + 32'd1;
        end
        WAIT_RUN: begin
          // A run seen on the final count still wins over the timeout.
          if (run_s2) begin
            running  <= 1'b1;
            stop_cnt <= '0;
            state    <= RUNNING;
          end else if (cnt == RUN_END) begin
            timeout    <= 1'b1;
            word_count <= '0;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end else cnt <= cnt + 32'd1;
        end
        RUNNING: begin
          if (!run_s2) begin
            halted     <= 1'b1;
            running    <= 1'b0;
            word_count <= '0;
            nstop_sw   <= 1'b1;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end else if (!nstop_sw) begin
            if (stop_cnt == PULSE_END) nstop_sw <= 1'b1;
            else stop_cnt <= stop_cnt + 32'd1;
          end else if (stop_req) begin
            nstop_sw <= 1'b0;
            stop_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q2_panel_driver.sv
// Randomized bench for q2_panel_driver: every cycle's switch and status outputs are compared
// against a timeline model derived from the pulse/gap/timeout parameters.
module tb_q2_panel_driver;
  localparam int P = 2;
  localparam int G = 3;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, in_ready, stop_req, run;
  logic [11:0] in_data, nsw, word_count;
  logic        ndep_sw, nincp_sw, nstart_sw, nstop_sw;
  logic        busy, running, halted, timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_wc  = '0;
  logic        exp_to  = 1'b0;

  q2_panel_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .RUN_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .stop_req(stop_req), .run(run),
    .nsw(nsw), .ndep_sw(ndep_sw), .nincp_sw(nincp_sw), .nstart_sw(nstart_sw), .nstop_sw(nstop_sw),
    .busy(busy), .running(running), .halted(halted), .timeout(timeout), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [11:0] e_nsw, input bit e_dep,
                            input bit e_inc, input bit e_start, input bit e_stop,
                            input bit e_rdy, input bit e_run, input bit e_halt);
    chk({tag, ".sw"}, {16'h0, nsw, ndep_sw, nincp_sw, nstart_sw, nstop_sw},
        {16'h0, e_nsw, e_dep, e_inc, e_start, e_stop});
    chk({tag, ".st"}, {15'h0, in_ready, busy, running, halted, timeout, word_count},
        {15'h0, e_rdy, !e_rdy, e_run, e_halt, exp_to, exp_wc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      stop_req = $urandom_range(0, 1) == 1;
      tick();
      stop_req = 1'b0;
      expect_out("idle", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);
    end
  endtask

  // Offers a word and follows it through setup, deposit, increment and the final settle.
  task automatic send(input logic [11:0] d, input bit last, input bit hold);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    chk("accept_ready", {31'h0, in_ready}, 32'h1);
    tick();
    if (exp_wc == 12'd0) exp_to = 1'b0;
    in_valid = hold; in_data = 12'($urandom); in_last = 1'b0;
    for (int k = 0; k < 3*G + 2*P; k++) begin
      stop_req = $urandom_range(0, 3) == 0;
      expect_out("word", ~d, !(k >= G && k < G+P), !(k >= 2*G+P && k < 2*G+2*P), 1, 1, 0, 0, 0);
      tick();
    end
    stop_req = 1'b0;
    exp_wc = exp_wc + 12'd1;
    if (!last) expect_out("word_done", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);
  endtask

  task automatic start_phase();
    for (int k = 0; k < P; k++) begin
      expect_out("start", 12'hFFF, 1, 1, 0, 1, 0, 0, 0);
      tick();
    end
  endtask

  // Index 0 is the first sample after start release; run is first sampled at edge D and dropped at edge D+L.
  task automatic run_phase(input int d, input int l, input bit do_stop, input int q);
    bit fin;
    for (int i = 0; i <= d + l + 2; i++) begin
      fin = (i == d + l + 2);
      if (fin) exp_wc = '0;
      expect_out("run", 12'hFFF, 1, 1, 1, !(do_stop && i >= q && i < q + P), fin,
                 (i >= d + 2 && i <= d + l + 1), fin);
      run      = (i + 1 >= d) && (i + 1 < d + l);
      stop_req = do_stop && (i + 1 == q || i + 1 == q + 1);
      if (!fin) tick();
    end
    run = 1'b0; stop_req = 1'b0;
  endtask

  task automatic timeout_phase();
    bit fin;
    for (int i = 0; i <= T; i++) begin
      fin = (i == T);
      if (fin) begin exp_to = 1'b1; exp_wc = '0; end
      expect_out("wait_to", 12'hFFF, 1, 1, 1, 1, fin, 0, 0);
      stop_req = $urandom_range(0, 2) == 0;
      if (!fin) tick();
    end
    stop_req = 1'b0;
  endtask

  task automatic random_run();
    int d, l, q;
    d = $urandom_range(1, 15);
    l = $urandom_range(6, 30);
    q = $urandom_range(d + l + 2 - P, d + 3);
    run_phase(d, l, $urandom_range(0, 1) == 1, q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; stop_req = 1'b0; run = 1'b0;
    #1;
    expect_out("reset", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    expect_out("post_reset", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);

    send(12'h5A3, 1'b0, 1'b0);
    idle_cycles(2);

    // Reset asserted while the deposit switch is held low.
    in_valid = 1'b1; in_data = 12'h3C7; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (G) tick();
    chk("mid_dep_low", {31'h0, ndep_sw}, 32'h0);
    #1 rst = 1'b1;
    #1;
    exp_wc = '0; exp_to = 1'b0;
    expect_out("rst_mid_dep", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    expect_out("after_rst_mid", 12'hFFF, 1, 1, 1, 1, 1, 0, 0);

    send(12'h111, 1'b0, 1'b1);
    send(12'h222, 1'b0, 1'b1);
    send(12'h333, 1'b1, 1'b0);
    start_phase();
    run_phase(5, 50, 1'b1, 20);
    idle_cycles(2);

    send(12'hABC, 1'b1, 1'b0);
    start_phase();
    timeout_phase();
    idle_cycles(2);
    send(12'h0F0, 1'b0, 1'b0);

    for (int p = 0; p < 12; p++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        idle_cycles($urandom_range(0, 2));
        send(12'($urandom), w == nw - 1, $urandom_range(0, 1) == 1);
      end
      start_phase();
      if ($urandom_range(0, 3) == 0) timeout_phase();
      else random_run();
    end
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
